// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini_alu_core datapath: opcodes, instruction
// field layout and the decoded instruction payload.
package mini_alu_pkg;

  localparam int unsigned INSTR_W  = 28;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned FIELD_W  = 8;

  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC0_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_STO  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_INC  = 4'd4;
  localparam logic [OP_W-1:0] OP_BLE  = 4'd5;
  localparam logic [OP_W-1:0] OP_BGE  = 4'd6;
  localparam logic [OP_W-1:0] OP_JMP  = 4'd7;
  localparam logic [OP_W-1:0] OP_CALL = 4'd8;
  localparam logic [OP_W-1:0] OP_RET  = 4'd9;
  localparam logic [OP_W-1:0] OP_VGA  = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd11;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [FIELD_W-1:0] dst;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src0;
  } instr_t;

  localparam instr_t INSTR_NOP = '0;

  // Split a raw ROM word into its fields
  function automatic instr_t decode_instr(logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op   = raw[OP_LSB   +: OP_W];
    d.dst  = raw[DST_LSB  +: FIELD_W];
    d.src1 = raw[SRC1_LSB +: FIELD_W];
    d.src0 = raw[SRC0_LSB +: FIELD_W];
    return d;
  endfunction

endpackage

// File: rtl/mini_alu_ret_stack.sv
// Hardware return-address stack. Push and pop are expected to be qualified
// by the caller against full/empty; top is the most recently pushed entry.
module mini_alu_ret_stack #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

  logic [PTR_W:0]          sp;
  logic [ADDR_WIDTH-1:0]   mem [STACK_DEPTH];
  logic [PTR_W-1:0]        top_idx;

  assign full     = (sp == (PTR_W+1)'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = PTR_W'(sp - (PTR_W+1)'(1));
  assign top_addr = mem[top_idx];

  // Stack pointer: counts live entries
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + (PTR_W+1)'(1);
    end else if (pop) begin
      sp <= sp - (PTR_W+1)'(1);
    end
  end

  // Entry storage; contents beyond sp are don't-care so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[PTR_W'(sp)] <= push_addr;
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage MiniAlu datapath: fetch register (IR/execIP) feeding an execute
// stage with register file, return stack and a valid/ready VGA write port.
// Optional MUL opcode is enabled by defining MINI_ALU_MUL_EN.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oIP,
  input  logic [27:0]           iInstruction,
  output logic                  oVgaValid,
  input  logic                  iVgaReady,
  output logic [15:0]           oVgaAddr,
  output logic [2:0]            oVgaColor,
  output logic                  oStackError,
  input  logic [7:0]            iDbgAddr,
  output logic [DATA_WIDTH-1:0] oDbgData
);

  localparam int unsigned REG_AW = $clog2(REG_COUNT);

  instr_t                ir;
  instr_t                ir_next;
  logic [ADDR_WIDTH-1:0] exec_ip;
  logic [ADDR_WIDTH-1:0] ip_next;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] src1_data;
  logic [DATA_WIDTH-1:0] src0_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [REG_AW-1:0]     src1_idx;
  logic [REG_AW-1:0]     src0_idx;
  logic [REG_AW-1:0]     dst_idx;
  logic                  wr_en;
  logic                  taken;
  logic                  stall;
  logic                  push;
  logic                  pop;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  stack_fault;
  logic                  unused_bits;

  assign src1_idx  = REG_AW'(ir.src1);
  assign src0_idx  = REG_AW'(ir.src0);
  assign dst_idx   = REG_AW'(ir.dst);
  assign src1_data = regs[src1_idx];
  assign src0_data = regs[src0_idx];
  assign oDbgData  = regs[REG_AW'(iDbgAddr)];

  // Pixel request is a direct decode of the held instruction register
  assign oVgaValid = (ir.op == OP_VGA);
  assign stall     = oVgaValid && !iVgaReady;
  assign oVgaAddr  = {8'(src1_data), 8'(src0_data)};
  assign oVgaColor = ir.dst[2:0];

  // Bits deliberately dropped by the narrowing casts above
  assign unused_bits = ^{iDbgAddr, src1_data, src0_data};

  // Execute-stage decode plus next fetch state
  always_comb begin
    wr_en       = 1'b0;
    wr_data     = '0;
    taken       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    stack_fault = 1'b0;
    target      = ADDR_WIDTH'(ir.dst);
    case (ir.op)
      OP_STO: begin
        wr_en   = 1'b1;
        wr_data = DATA_WIDTH'({ir.src1, ir.src0});
      end
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_data = src1_data + src0_data;
      end
      OP_SUB: begin
        wr_en   = 1'b1;
        wr_data = src1_data - src0_data;
      end
      OP_INC: begin
        wr_en   = 1'b1;
        wr_data = src1_data + DATA_WIDTH'(1);
      end
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin
        wr_en   = 1'b1;
        wr_data = DATA_WIDTH'(src1_data * src0_data);
      end
`else
      OP_MUL: ;
`endif
      OP_BLE: taken = (src1_data <= src0_data);
      OP_BGE: taken = (src1_data >= src0_data);
      OP_JMP: taken = 1'b1;
      OP_CALL: begin
        taken       = 1'b1;
        push        = !stack_full;
        stack_fault = stack_full;
      end
      OP_RET: begin
        if (stack_empty) begin
          stack_fault = 1'b1;
        end else begin
          taken  = 1'b1;
          pop    = 1'b1;
          target = ret_addr;
        end
      end
      default: ;
    endcase

    ip_next = oIP + ADDR_WIDTH'(1);
    ir_next = decode_instr(iInstruction);
    if (taken) begin
      ip_next = target;
      ir_next = INSTR_NOP;
    end
  end

  // Fetch/decode pipeline registers; frozen while a pixel write waits
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oIP     <= '0;
      ir      <= INSTR_NOP;
      exec_ip <= '0;
    end else if (!stall) begin
      oIP     <= ip_next;
      ir      <= ir_next;
      exec_ip <= oIP;
    end
  end

  // Register file write port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && !stall) begin
      regs[dst_idx] <= wr_data;
    end
  end

  // Sticky overflow/underflow flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oStackError <= 1'b0;
    end else if (stack_fault && !stall) begin
      oStackError <= 1'b1;
    end
  end

  mini_alu_ret_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (Clock),
    .rst       (Reset),
    .push      (push && !stall),
    .pop       (pop && !stall),
    .push_addr (exec_ip + ADDR_WIDTH'(1)),
    .top_addr  (ret_addr),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule
